// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the 16-bit data memory and returns load/ALU results to WB.
// Optional MEM_ADDR_CHECK_EN: out-of-range load/store addresses are suppressed and flagged.
module mem_access_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                  CLOCK,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  output logic [ADDR_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_mem_wdata,
  output logic                  out_cntrl_mem_read,
  output logic                  out_cntrl_mem_write,
  input  logic [DATA_W-1:0]     in_mem_rdata,
  output logic                  out_wb_valid,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic [REG_ADDR_W-1:0] out_wb_rd,
  output logic                  out_wb_reg_write,
  output logic                  out_illegal
);

  typedef enum logic [1:0] {StIdle, StLdWait, StLdCapt} state_e;

  state_e state_q, state_d;

  logic                  ready_q, ready_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_rw_q, wb_rw_d;
  logic                  illegal_q, illegal_d;
  // Destination of the load in flight, held until the data comes back.
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_rw_q, ld_rw_d;
  logic                  ld_zero_q, ld_zero_d;

  logic accept;
  logic is_load, is_store, is_both;
  logic addr_oor;

  assign accept   = in_valid & ready_q;
  assign is_load  = in_mem_read & ~in_mem_write;
  assign is_store = in_mem_write & ~in_mem_read;
  assign is_both  = in_mem_read & in_mem_write;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_oor = (32'(in_alu_result) >= MEM_DEPTH);
`else
  assign addr_oor = 1'b0;
`endif

  always_ff @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      illegal_q   <= 1'b0;
      ld_rd_q     <= '0;
      ld_rw_q     <= 1'b0;
      ld_zero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      illegal_q   <= illegal_d;
      ld_rd_q     <= ld_rd_d;
      ld_rw_q     <= ld_rw_d;
      ld_zero_q   <= ld_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && is_load) state_d = StLdWait;
      StLdWait: state_d = StLdCapt;
      StLdCapt: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d     = (state_d == StIdle);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    illegal_d   = 1'b0;
    ld_rd_d     = ld_rd_q;
    ld_rw_d     = ld_rw_q;
    ld_zero_d   = ld_zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_both) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = in_rd_addr;
            wb_rw_d    = 1'b0;
            illegal_d  = 1'b1;
          end else if (is_store) begin
            mem_addr_d  = ADDR_W'(in_alu_result);
            mem_wdata_d = in_store_data;
            mem_wr_d    = ~addr_oor;
            wb_valid_d  = 1'b1;
            wb_rd_d     = in_rd_addr;
            wb_rw_d     = 1'b0;
            illegal_d   = addr_oor;
          end else if (is_load) begin
            mem_addr_d = ADDR_W'(in_alu_result);
            mem_rd_d   = ~addr_oor;
            ld_rd_d    = in_rd_addr;
            ld_rw_d    = in_reg_write;
            ld_zero_d  = addr_oor;
            illegal_d  = addr_oor;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = in_alu_result;
            wb_rd_d    = in_rd_addr;
            wb_rw_d    = in_reg_write;
          end
        end
      end
      StLdWait: ;
      StLdCapt: begin
        wb_valid_d = 1'b1;
        wb_data_d  = ld_zero_q ? '0 : in_mem_rdata;
        wb_rd_d    = ld_rd_q;
        wb_rw_d    = ld_rw_q;
      end
      default: ;
    endcase
  end

  assign out_ready           = ready_q;
  assign out_mem_addr        = mem_addr_q;
  assign out_mem_wdata       = mem_wdata_q;
  assign out_cntrl_mem_read  = mem_rd_q;
  assign out_cntrl_mem_write = mem_wr_q;
  assign out_wb_valid        = wb_valid_q;
  assign out_wb_data         = wb_data_q;
  assign out_wb_rd           = wb_rd_q;
  assign out_wb_reg_write    = wb_rw_q;
  assign out_illegal         = illegal_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small data-memory model
// (negedge write, posedge registered read, word 0 resets to 0x1234).
module tb_mem_access_stage;

  logic        CLOCK = 1'b0;
  logic        in_rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_alu_result;
  logic [15:0] in_store_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic [2:0]  in_rd_addr;
  logic [15:0] out_mem_addr;
  logic [15:0] out_mem_wdata;
  logic        out_cntrl_mem_read;
  logic        out_cntrl_mem_write;
  logic [15:0] in_mem_rdata;
  logic        out_wb_valid;
  logic [15:0] out_wb_data;
  logic [2:0]  out_wb_rd;
  logic        out_wb_reg_write;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];

  always #5 CLOCK = ~CLOCK;

  mem_access_stage dut (
    .CLOCK               (CLOCK),
    .in_rst              (in_rst),
    .in_valid            (in_valid),
    .out_ready           (out_ready),
    .in_alu_result       (in_alu_result),
    .in_store_data       (in_store_data),
    .in_mem_read         (in_mem_read),
    .in_mem_write        (in_mem_write),
    .in_reg_write        (in_reg_write),
    .in_rd_addr          (in_rd_addr),
    .out_mem_addr        (out_mem_addr),
    .out_mem_wdata       (out_mem_wdata),
    .out_cntrl_mem_read  (out_cntrl_mem_read),
    .out_cntrl_mem_write (out_cntrl_mem_write),
    .in_mem_rdata        (in_mem_rdata),
    .out_wb_valid        (out_wb_valid),
    .out_wb_data         (out_wb_data),
    .out_wb_rd           (out_wb_rd),
    .out_wb_reg_write    (out_wb_reg_write),
    .out_illegal         (out_illegal)
  );

  always @(negedge CLOCK) begin
    if (out_cntrl_mem_write) mem[out_mem_addr[7:0]] <= out_mem_wdata;
  end

  always @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) in_mem_rdata <= 16'h0000;
    else if (out_cntrl_mem_read) in_mem_rdata <= mem[out_mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic rd, input logic wr, input logic rw, input logic [2:0] dst);
    in_valid      = v;
    in_alu_result = alu;
    in_store_data = sd;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_reg_write  = rw;
    in_rd_addr    = dst;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    in_rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    chk("rst_ready", out_ready, 1);
    chk("rst_wb_valid", out_wb_valid, 0);
    chk("rst_rd_strobe", out_cntrl_mem_read, 0);
    chk("rst_wr_strobe", out_cntrl_mem_write, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_addr", out_mem_addr, 0);
    chk("rst_wb_data", out_wb_data, 0);
    in_rst = 1'b0;

    // Load addr 0 right after reset; a different ALU op is held while the load is busy.
    drive(1'b1, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2);
    step();
    chk("ld0_rd_strobe", out_cntrl_mem_read, 1);
    chk("ld0_addr", out_mem_addr, 16'h0000);
    chk("ld0_ready_n", out_ready, 0);
    chk("ld0_wb_n", out_wb_valid, 0);
    drive(1'b1, 16'h0077, 16'h0, 1'b0, 1'b0, 1'b1, 3'd5);
    step();
    chk("ld0_rd_drop", out_cntrl_mem_read, 0);
    chk("ld0_ready_n1", out_ready, 0);
    chk("ld0_wb_n1", out_wb_valid, 0);
    step();
    chk("ld0_wb_valid", out_wb_valid, 1);
    chk("ld0_wb_data", out_wb_data, 16'h1234);
    chk("ld0_wb_rd", out_wb_rd, 2);
    chk("ld0_wb_rw", out_wb_reg_write, 1);
    chk("ld0_ready", out_ready, 1);
    step();
    chk("held_alu_valid", out_wb_valid, 1);
    chk("held_alu_data", out_wb_data, 16'h0077);
    chk("held_alu_rd", out_wb_rd, 5);

    // ALU op, then store, then load back-to-back.
    drive(1'b1, 16'h00A5, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3);
    step();
    chk("alu_valid", out_wb_valid, 1);
    chk("alu_data", out_wb_data, 16'h00A5);
    chk("alu_rd", out_wb_rd, 3);
    chk("alu_rw", out_wb_reg_write, 1);
    chk("alu_no_strobe", {out_cntrl_mem_read, out_cntrl_mem_write}, 0);
    drive(1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0);
    step();
    chk("st_wr_strobe", out_cntrl_mem_write, 1);
    chk("st_rd_strobe", out_cntrl_mem_read, 0);
    chk("st_addr", out_mem_addr, 16'h0005);
    chk("st_wdata", out_mem_wdata, 16'hBEEF);
    chk("st_wb_valid", out_wb_valid, 1);
    chk("st_wb_rw", out_wb_reg_write, 0);
    drive(1'b1, 16'h0005, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4);
    step();
    chk("st_wr_drop", out_cntrl_mem_write, 0);
    chk("ld5_rd_strobe", out_cntrl_mem_read, 1);
    chk("ld5_addr", out_mem_addr, 16'h0005);
    chk("ld5_wb_n", out_wb_valid, 0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk("ld5_rd_drop", out_cntrl_mem_read, 0);
    chk("ld5_addr_hold", out_mem_addr, 16'h0005);
    step();
    chk("ld5_wb_valid", out_wb_valid, 1);
    chk("ld5_wb_data", out_wb_data, 16'hBEEF);
    chk("ld5_wb_rd", out_wb_rd, 4);
    step();
    chk("ld5_wb_pulse", out_wb_valid, 0);

    // Read and write both set.
    drive(1'b1, 16'h0009, 16'h1111, 1'b1, 1'b1, 1'b1, 3'd6);
    step();
    chk("ill_flag", out_illegal, 1);
    chk("ill_wb_valid", out_wb_valid, 1);
    chk("ill_wb_rw", out_wb_reg_write, 0);
    chk("ill_no_strobe", {out_cntrl_mem_read, out_cntrl_mem_write}, 0);
    chk("ill_ready", out_ready, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk("ill_pulse", out_illegal, 0);
    chk("ill_wb_pulse", out_wb_valid, 0);

    // Reset during LD_WAIT drops the load.
    drive(1'b1, 16'h0005, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
    step();
    chk("rl_rd_strobe", out_cntrl_mem_read, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    #2 in_rst = 1'b1;
    #1;
    chk("rl_rd_clear", out_cntrl_mem_read, 0);
    chk("rl_ready", out_ready, 1);
    step();
    step();
    chk("rl_no_wb", out_wb_valid, 0);
    in_rst = 1'b0;
    step();
    chk("rl_no_wb2", out_wb_valid, 0);
    drive(1'b1, 16'h0042, 16'h0, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    chk("rl_alu_valid", out_wb_valid, 1);
    chk("rl_alu_data", out_wb_data, 16'h0042);
    chk("rl_alu_rd", out_wb_rd, 1);

    // Load beyond the implemented memory.
    drive(1'b1, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 3'd7);
    mem[8'h20] = 16'h5A5A;
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
`ifdef MEM_ADDR_CHECK_EN
    chk("oor_ld_illegal", out_illegal, 1);
    chk("oor_ld_no_rd", out_cntrl_mem_read, 0);
    chk("oor_ld_ready_n", out_ready, 0);
    step();
    chk("oor_ld_no_rd1", out_cntrl_mem_read, 0);
    step();
    chk("oor_ld_valid", out_wb_valid, 1);
    chk("oor_ld_data", out_wb_data, 0);
    chk("oor_ld_rw", out_wb_reg_write, 1);
    chk("oor_ld_rd", out_wb_rd, 7);
    drive(1'b1, 16'h0030, 16'hCAFE, 1'b0, 1'b1, 1'b0, 3'd0);
    step();
    chk("oor_st_no_wr", out_cntrl_mem_write, 0);
    chk("oor_st_illegal", out_illegal, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk("oor_st_dropped", mem[8'h30], 16'h0000);
`else
    chk("far_ld_illegal", out_illegal, 0);
    chk("far_ld_rd", out_cntrl_mem_read, 1);
    chk("far_ld_addr", out_mem_addr, 16'h0020);
    step();
    step();
    chk("far_ld_valid", out_wb_valid, 1);
    chk("far_ld_data", out_wb_data, 16'h5A5A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
